// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the LEGv8 load/store unit.
package lsu_pkg;

  // Access size encodings as carried on reqSize.
  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } sizeT;

  // Control states of the access sequencer.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } stateT;

  // Number of bytes moved by an access of the given size (1, 2, 4 or 8).
  function automatic logic [3:0] sizeBytes(input sizeT size);
    return 4'd1 << size;
  endfunction

  // True when the low address bits are not a multiple of the access size.
  function automatic logic isMisaligned(input sizeT size, input logic [2:0] lowAddr);
    logic [2:0] alignMask;
    alignMask = 3'(sizeBytes(size) - 4'd1);
    return (lowAddr & alignMask) != 3'b000;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signals of the load/store unit.
interface load_store_unit_if;

  // Request from execute.
  logic        reqValid;
  logic        reqReady;
  logic        reqIsStore;
  logic [1:0]  reqSize;
  logic        reqSigned;
  logic [63:0] reqAddress;
  logic [63:0] reqStoreData;
  logic [4:0]  reqDest;

  // Data memory, doubleword wide with combinational read.
  logic [63:0] memAddress;
  logic [63:0] memWriteData;
  logic        memRead;
  logic        memWrite;
  logic [63:0] memReadData;

  // Response to write-back.
  logic        rspValid;
  logic        rspReady;
  logic [63:0] rspData;
  logic [4:0]  rspDest;
  logic        rspIsStore;
  logic        rspFault;

  // The load/store unit itself.
  modport slave (
    input  reqValid, reqIsStore, reqSize, reqSigned, reqAddress, reqStoreData, reqDest,
    output reqReady,
    output memAddress, memWriteData, memRead, memWrite,
    input  memReadData,
    output rspValid, rspData, rspDest, rspIsStore, rspFault,
    input  rspReady
  );

  // The surroundings: execute stage, data memory and write-back.
  modport master (
    output reqValid, reqIsStore, reqSize, reqSigned, reqAddress, reqStoreData, reqDest,
    input  reqReady,
    input  memAddress, memWriteData, memRead, memWrite,
    output memReadData,
    input  rspValid, rspData, rspDest, rspIsStore, rspFault,
    output rspReady
  );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering: load extraction/extension and store read-modify-write merge.
module lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  lane,
  input  sizeT        size,
  input  logic        isSigned,
  input  logic [63:0] readData,
  input  logic [63:0] storeData,
  output logic [63:0] loadData,
  output logic [63:0] mergedData
);

  logic [5:0]  shiftBits;
  logic [63:0] shifted;
  logic [63:0] sizeMask;
  logic [63:0] laneMask;

  // Little-endian lane select for loads and byte-masked merge for stores.
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
    shiftBits  = {lane, 3'b000};
    shifted    = readData >> shiftBits;
    // A shift by 64 yields zero, so the doubleword mask is all ones.
    sizeMask   = ~(64'hFFFF_FFFF_FFFF_FFFF << {sizeBytes(size), 3'b000});
    loadData   = shifted & sizeMask;
    if (isSigned) begin
      case (size)
        SIZE_B:  loadData = {{56{shifted[7]}},  shifted[7:0]};
        SIZE_H:  loadData = {{48{shifted[15]}}, shifted[15:0]};
        SIZE_W:  loadData = {{32{shifted[31]}}, shifted[31:0]};
        default: loadData = shifted & sizeMask;
      endcase
    end
    laneMask   = sizeMask << shiftBits;
    mergedData = (readData & ~laneMask) | ((storeData << shiftBits) & laneMask);
  end

endmodule

// File: rtl/load_store_unit.sv
// LEGv8 memory-stage load/store unit: one request at a time, read-modify-write
// for sub-doubleword stores, sign-extending loads, fault detection before any
// memory access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES  = 128,
  parameter int DATA_WIDTH = 64
) (
  input logic             clock,
  input logic             resetN,
  load_store_unit_if.slave bus
);

  stateT state;
  stateT nextState;

  sizeT  reqSizeT;
  logic  reqFault;
  logic  reqIsDwStore;
  logic  accept;

  logic [2:0]            laneQ;
  sizeT                  sizeQ;
  logic                  signedQ;
  logic                  isStoreQ;
  logic [DATA_WIDTH-1:0] storeDataQ;

  logic [63:0] loadData;
  logic [63:0] mergedData;

  assign reqSizeT     = sizeT'(bus.reqSize);
  assign reqFault     = isMisaligned(reqSizeT, bus.reqAddress[2:0]) ||
                        (bus.reqAddress >= 64'(MEM_BYTES));
  assign reqIsDwStore = bus.reqIsStore && (reqSizeT == SIZE_D);
  assign accept       = (state == IDLE) && bus.reqValid;

  // Only the idle state takes new work.
  assign bus.reqReady = (state == IDLE);

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!resetN) state <= IDLE;
    else         state <= nextState;
  end

  // Next-state decode.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (bus.reqValid) begin
          if (reqFault)          nextState = RESP;
          else if (reqIsDwStore) nextState = WRITE;
          else                   nextState = READ;
        end
      end
      READ:    nextState = isStoreQ ? WRITE : RESP;
      WRITE:   nextState = RESP;
      RESP:    if (bus.rspReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Registered strobes decoded from the state being entered, so each is high for exactly its state.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      bus.memRead  <= 1'b0;
      bus.memWrite <= 1'b0;
      bus.rspValid <= 1'b0;
    end else begin
      bus.memRead  <= (nextState == READ);
      bus.memWrite <= (nextState == WRITE);
      bus.rspValid <= (nextState == RESP);
    end
  end

  // Request capture on acceptance, then read-data use at the end of READ.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      laneQ            <= 3'b000;
      sizeQ            <= SIZE_B;
      signedQ          <= 1'b0;
      isStoreQ         <= 1'b0;
      storeDataQ       <= '0;
      bus.memAddress   <= 64'd0;
      bus.memWriteData <= 64'd0;
      bus.rspData      <= 64'd0;
      bus.rspDest      <= 5'd0;
      bus.rspIsStore   <= 1'b0;
      bus.rspFault     <= 1'b0;
    end else if (accept) begin
      laneQ          <= bus.reqAddress[2:0];
      sizeQ          <= reqSizeT;
      signedQ        <= bus.reqSigned;
      isStoreQ       <= bus.reqIsStore;
      storeDataQ     <= bus.reqStoreData;
      bus.memAddress <= {bus.reqAddress[63:3], 3'b000};
      bus.rspData    <= 64'd0;
      bus.rspDest    <= bus.reqDest;
      bus.rspIsStore <= bus.reqIsStore;
      bus.rspFault   <= reqFault;
      // A full doubleword store needs no read, so its data goes out as-is.
      if (reqIsDwStore) bus.memWriteData <= bus.reqStoreData;
    end else if (state == READ) begin
      if (isStoreQ) bus.memWriteData <= mergedData;
      else          bus.rspData      <= loadData;
    end
  end

  lane_align u_laneAlign (
    .lane       (laneQ),
    .size       (sizeQ),
    .isSigned   (signedQ),
    .readData   (bus.memReadData),
    .storeData  (storeDataQ),
    .loadData   (loadData),
    .mergedData (mergedData)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// traffic against a byte-array reference memory.
module tb_load_store_unit;

  localparam int MEM_BYTES = 128;

  logic clock;
  logic resetN;
  logic preload;

  int total;
  int bad;

  logic [7:0]  refMem [0:MEM_BYTES-1];
  logic [63:0] dmem   [0:MEM_BYTES/8-1];

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(MEM_BYTES), .DATA_WIDTH(64)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: little-endian doubleword assembled from the byte array.
  function automatic logic [63:0] refWord(input int base);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < 8; i++) v = v | (64'(refMem[base + i]) << (8 * i));
    return v;
  endfunction

  // Reference load: gather n bytes, optionally sign-extend from the top byte.
  function automatic logic [63:0] refLoad(input int a, input int n, input bit sgn);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < n; i++) v = v | (64'(refMem[a + i]) << (8 * i));
    if (sgn && n < 8 && refMem[a + n - 1][7]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8 * n));
    return v;
  endfunction

  // Data memory: combinational read, write on the clock edge.
  assign bus.memReadData = dmem[bus.memAddress[6:3]];

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < MEM_BYTES / 8; i++) dmem[i] <= refWord(i * 8);
    end else if (bus.memWrite) begin
      dmem[bus.memAddress[6:3]] <= bus.memWriteData;
    end
  end

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, actual, expected);
    end
  endtask

  task automatic scrambleReq();
    bus.reqIsStore   = 1'($urandom);
    bus.reqSize      = 2'($urandom);
    bus.reqSigned    = 1'($urandom);
    bus.reqAddress   = {$urandom, $urandom};
    bus.reqStoreData = {$urandom, $urandom};
    bus.reqDest      = 5'($urandom);
  endtask

  // One complete transaction, entered and left on a falling edge.
  task automatic doReq(input bit isSt, input logic [1:0] sz, input bit sgn,
                       input logic [63:0] addr, input logic [63:0] data,
                       input logic [4:0] dest, input int hold);
    int          n;
    bit          fault;
    logic [63:0] base;
    logic [63:0] expData;
    logic [63:0] expWord;
    int          expRsp;
    int          expRead;
    int          expWrite;
    int          firstRead;
    int          firstWrite;
    int          firstRsp;
    int          nRead;
    int          nWrite;

    n        = 1 << sz;
    fault    = ((addr & 64'(n - 1)) != 64'd0) || (addr >= 64'(MEM_BYTES));
    base     = addr & ~64'h7;
    expData  = 64'd0;
    expWord  = 64'd0;
    if (!fault && !isSt) expData = refLoad(int'(addr), n, sgn);
    if (!fault && isSt) begin
      for (int i = 0; i < n; i++) refMem[int'(addr) + i] = data[8 * i +: 8];
      expWord = refWord(int'(base));
    end
    expRsp   = fault ? 1 : ((isSt && n < 8) ? 3 : 2);
    expRead  = (fault || (isSt && n == 8)) ? 0 : 1;
    expWrite = (fault || !isSt) ? 0 : ((n == 8) ? 1 : 2);

    check("reqReady idle", 64'(bus.reqReady), 64'd1);
    bus.reqValid     = 1'b1;
    bus.reqIsStore   = isSt;
    bus.reqSize      = sz;
    bus.reqSigned    = sgn;
    bus.reqAddress   = addr;
    bus.reqStoreData = data;
    bus.reqDest      = dest;
    @(posedge clock);
    @(negedge clock);
    bus.reqValid = 1'b0;
    scrambleReq();

    firstRead  = 0;
    firstWrite = 0;
    firstRsp   = 0;
    nRead      = 0;
    nWrite     = 0;
    for (int c = 1; c <= 8 && firstRsp == 0; c++) begin
      if (c > 1) @(negedge clock);
      if (bus.memRead || bus.memWrite) begin
        check("strobe exclusive", 64'(bus.memRead & bus.memWrite), 64'd0);
        check("memAddress", bus.memAddress, base);
      end
      if (bus.memRead) begin
        nRead++;
        if (firstRead == 0) firstRead = c;
      end
      if (bus.memWrite) begin
        nWrite++;
        if (firstWrite == 0) firstWrite = c;
        check("memWriteData", bus.memWriteData, expWord);
      end
      if (bus.rspValid) firstRsp = c;
    end

    if (firstRsp == 0) begin
      check("rspValid timeout", 64'(bus.rspValid), 64'd1);
    end else begin
      check("rsp latency", 64'(firstRsp), 64'(expRsp));
      check("read cycle", 64'(firstRead), 64'(expRead));
      check("write cycle", 64'(firstWrite), 64'(expWrite));
      check("read count", 64'(nRead), 64'(expRead != 0));
      check("write count", 64'(nWrite), 64'(expWrite != 0));
      check("rspData", bus.rspData, expData);
      check("rspDest", 64'(bus.rspDest), 64'(dest));
      check("rspIsStore", 64'(bus.rspIsStore), 64'(isSt));
      check("rspFault", 64'(bus.rspFault), 64'(fault));
      for (int h = 0; h < hold; h++) begin
        @(negedge clock);
        check("hold rspValid", 64'(bus.rspValid), 64'd1);
        check("hold rspData", bus.rspData, expData);
        check("hold reqReady", 64'(bus.reqReady), 64'd0);
        check("hold no strobe", 64'(bus.memRead | bus.memWrite), 64'd0);
      end
    end

    bus.rspReady = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.rspReady = 1'b0;
    check("rspValid dropped", 64'(bus.rspValid), 64'd0);
    check("reqReady back", 64'(bus.reqReady), 64'd1);
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [63:0] addr;
    int          n;

    total    = 0;
    bad      = 0;
    resetN   = 1'b0;
    preload  = 1'b1;
    bus.reqValid = 1'b0;
    bus.rspReady = 1'b0;
    scrambleReq();

    for (int i = 0; i < MEM_BYTES; i++) refMem[i] = 8'($urandom);
    refMem[16] = 8'h02;
    for (int i = 17; i < 24; i++) refMem[i] = 8'h00;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset memRead", 64'(bus.memRead), 64'd0);
    check("reset memWrite", 64'(bus.memWrite), 64'd0);
    check("reset rspValid", 64'(bus.rspValid), 64'd0);
    check("reset memAddress", bus.memAddress, 64'd0);
    check("reset memWriteData", bus.memWriteData, 64'd0);
    check("reset rspData", bus.rspData, 64'd0);
    check("reset rspDest", 64'(bus.rspDest), 64'd0);
    check("reset rspIsStore", 64'(bus.rspIsStore), 64'd0);
    check("reset rspFault", 64'(bus.rspFault), 64'd0);
    check("reset reqReady", 64'(bus.reqReady), 64'd1);
    resetN  = 1'b1;
    preload = 1'b0;

    // Directed scenarios.
    doReq(1'b0, 2'b11, 1'b0, 64'd16, 64'd0, 5'd5, 0);
    doReq(1'b1, 2'b00, 1'b0, 64'd17, 64'h00000000000000AB, 5'd1, 0);
    doReq(1'b0, 2'b00, 1'b0, 64'd17, 64'd0, 5'd2, 0);
    doReq(1'b1, 2'b11, 1'b0, 64'd24, 64'hFFFF_FFFF_8000_0000, 5'd3, 0);
    doReq(1'b0, 2'b10, 1'b1, 64'd28, 64'd0, 5'd4, 0);
    doReq(1'b0, 2'b10, 1'b1, 64'd24, 64'd0, 5'd6, 0);
    doReq(1'b0, 2'b10, 1'b0, 64'd24, 64'd0, 5'd7, 0);
    doReq(1'b0, 2'b01, 1'b0, 64'd23, 64'd0, 5'd8, 0);
    doReq(1'b0, 2'b11, 1'b0, 64'd128, 64'd0, 5'd9, 0);
    doReq(1'b0, 2'b01, 1'b1, 64'd26, 64'd0, 5'd10, 4);

    // Reset during the READ of a sub-doubleword store must suppress the write.
    check("abort reqReady", 64'(bus.reqReady), 64'd1);
    bus.reqValid     = 1'b1;
    bus.reqIsStore   = 1'b1;
    bus.reqSize      = 2'b00;
    bus.reqSigned    = 1'b0;
    bus.reqAddress   = 64'd41;
    bus.reqStoreData = 64'h5A5A_5A5A_5A5A_5A5A ^ 64'(refMem[41]) ^ 64'h1;
    bus.reqDest      = 5'd11;
    @(posedge clock);
    @(negedge clock);
    bus.reqValid = 1'b0;
    check("abort in READ", 64'(bus.memRead), 64'd1);
    resetN = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("abort memWrite", 64'(bus.memWrite), 64'd0);
    check("abort rspValid", 64'(bus.rspValid), 64'd0);
    @(posedge clock);
    @(negedge clock);
    check("abort memWrite late", 64'(bus.memWrite), 64'd0);
    resetN = 1'b1;
    doReq(1'b0, 2'b11, 1'b0, 64'd40, 64'd0, 5'd12, 0);

    // Random traffic, mostly aligned and in range.
    for (int t = 0; t < 300; t++) begin
      sz   = 2'($urandom);
      n    = 1 << sz;
      addr = 64'($urandom_range(0, MEM_BYTES + 7));
      if ($urandom_range(0, 3) != 0) addr = addr & ~64'(n - 1);
      if ($urandom_range(0, 31) == 0) addr = {$urandom, $urandom};
      doReq(1'($urandom), sz, 1'($urandom), addr, {$urandom, $urandom},
            5'($urandom), ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
